// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for an unsigned 8x8 approximate multiplier: recomputes the exact
// product and accumulates sum/max error distance, error count and signed bias over 2^WIN_LOG2 samples.
module approx_mult_error_monitor #(
    parameter int WIN_LOG2 = 8,
    parameter int ACC_W    = 16 + WIN_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          x,
    input  logic [7:0]          y,
    input  logic [15:0]         z_apx,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    sum_ed,
    output logic [15:0]         max_ed,
    output logic [WIN_LOG2:0]   err_cnt,
    output logic [ACC_W:0]      bias,
    output logic [1:0]          fsm_state
);
    // Handshakes: a sample transfers on a rising edge with in_valid && in_ready; a result
    // transfers on a rising edge with res_valid && res_ready. Neither valid waits on ready.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIN_LOG2:0] cnt;
    logic              accept, last_accept, clear;

    logic              v1, v2;
    logic [7:0]        x1, y1;
    logic [15:0]       z1;
    logic [16:0]       d2;
    logic [15:0]       ed2;
    logic              ne2;

    logic [15:0]       exact;
    logic [16:0]       d, neg_d;
    logic [15:0]       ed;

    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign res_valid   = (state == DONE);
    assign fsm_state   = state;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (cnt == {1'b0, {WIN_LOG2{1'b1}}});
    assign clear       = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_accept) state_nxt = DRAIN;
            DRAIN:   if (!v1 && !v2) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (accept) cnt <= cnt + {{WIN_LOG2{1'b0}}, 1'b1};
    end

    // Stage 1: capture the accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            x1 <= '0;
            y1 <= '0;
            z1 <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                x1 <= x;
                y1 <= y;
                z1 <= z_apx;
            end
        end
    end

    // Signed difference is 17 bits so both +65535 and -65535 are representable.
    assign exact = {8'd0, x1} * {8'd0, y1};
    assign d     = {1'b0, z1} - {1'b0, exact};
    assign neg_d = 17'd0 - d;
    assign ed    = d[16] ? neg_d[15:0] : d[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            d2  <= '0;
            ed2 <= '0;
            ne2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                d2  <= d;
                ed2 <= ed;
                ne2 <= (d != 17'd0);
            end
        end
    end

    // Stage 3: accumulate; the window clear happens on the IDLE->RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
            bias    <= '0;
        end else if (clear) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
            bias    <= '0;
        end else if (v2) begin
            sum_ed  <= sum_ed + {{(ACC_W-16){1'b0}}, ed2};
            bias    <= bias + {{(ACC_W-16){d2[16]}}, d2};
            err_cnt <= err_cnt + {{WIN_LOG2{1'b0}}, ne2};
            if (ed2 > max_ed) max_ed <= ed2;
        end
    end
endmodule

// File: doc/approx_mult_error_monitor.md
Name: approx_mult_error_monitor

Overview:
- Downstream evaluation stage for the unsigned 8x8 approximate multipliers.
- Consumes a stream of operand pairs (x, y) together with the approximate product z_apx produced by the multiplier under test.
- Recomputes the exact product internally and accumulates error statistics over a fixed window of samples: sum of error distances, maximum error distance, erroneous-sample count and signed bias.
- Used in hardware-in-loop characterisation of the lamb/l sweep variants.

Parameters:
WIN_LOG2, 8, log2 of samples per window (window = 2^WIN_LOG2 samples)
ACC_W, 16+WIN_LOG2, width of the error-distance accumulator

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a window; honoured only in IDLE
in_valid  input  1  sample valid
in_ready  output  1  sample accepted when in_valid && in_ready at a rising edge
x  input  8  multiplicand
y  input  8  multiplier
z_apx  input  16  approximate product for (x, y)
busy  output  1  high in RUN or DRAIN
res_valid  output  1  results valid; held until res_ready
res_ready  input  1  result consumer handshake
sum_ed  output  ACC_W  sum of |z_apx - x*y| over the window
max_ed  output  16  maximum |z_apx - x*y| in the window
err_cnt  output  WIN_LOG2+1  number of samples with z_apx != x*y
bias  output  ACC_W+1  signed (two's complement) sum of (z_apx - x*y)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs, accumulators, pipeline valids and the sample counter are 0.
  - Reset mid-window discards everything; no partial result is emitted.
- FSM states and transitions:
  - IDLE: start=1 -> clear accumulators and counter -> RUN.
  - RUN: in_ready=1 while accepted count < 2^WIN_LOG2. The accepting edge of sample number 2^WIN_LOG2 -> DRAIN, and in_ready drops in the same edge.
  - DRAIN: in_ready=0; wait for the pipeline to empty -> DONE.
  - DONE: res_valid=1, outputs stable. res_valid && res_ready -> IDLE, and res_valid drops.
  - start outside IDLE is ignored.
  - start and res_ready in the same DONE cycle: handshake completes, start is ignored.
- Pipeline (3 stages, no bubbles required):
  - S1: register x, y, z_apx, valid on accept.
  - S2: exact = x*y (16-bit); d = {1'b0,z_apx} - {1'b0,exact} (17-bit signed); ed = |d| (16 bits, max 65535); ne = (d != 0); register these.
  - S3: sum_ed += ed; bias += sign-extended d; max_ed = max(max_ed, ed); err_cnt += ne.
  - Final sample accepted at edge E: accumulators updated at edge E+2, state DONE and res_valid=1 after edge E+3.
- Throughput: one sample per cycle in RUN. in_valid gaps are permitted and stall nothing downstream; pipeline valid bits track sample presence.
- Width rules:
  - sum_ed cannot overflow at the default ACC_W (2^WIN_LOG2 * 65535 < 2^ACC_W).
  - bias range is +/- 2^ACC_W.
  - err_cnt reaches 2^WIN_LOG2 exactly when every sample errs.
- Output stability: result outputs change only at the IDLE->RUN clear and during accumulation. Their values are meaningful only while res_valid=1.
- Input stability: x, y, z_apx are don't-care when in_valid=0. Samples offered outside RUN are not accepted (in_ready=0).

Test Plan:
- Reset: assert rst_n=0 mid-RUN after 2 accepted samples -> all outputs 0, in_ready=0, state IDLE. A subsequent start runs a full fresh window.
- Exact window (WIN_LOG2=2): samples (3,5,15),(255,255,65025),(0,77,0),(16,16,256) -> sum_ed=0, max_ed=0, err_cnt=0, bias=0, res_valid 3 cycles after the 4th accept.
- Mixed errors (WIN_LOG2=2): (3,5,15),(200,200,39744),(10,10,104),(1,1,1), i.e. errors 0,-256,+4,0 -> sum_ed=260, max_ed=256, err_cnt=2, bias=-252.
- Extreme: (255,255,0) x4 -> sum_ed=260100, max_ed=65025, err_cnt=4, bias=-260100 (WIN_LOG2=2, ACC_W=18 sized accordingly).
- Handshake: in_valid toggled 1,0,1,0 -> only 4 accepts counted; in_ready=0 after the 4th. res_ready held low 5 cycles -> res_valid and results hold, then drop one edge after res_ready=1.
- start pulses during RUN and DONE -> ignored; start and res_ready together in DONE -> returns to IDLE, no new window.
